// File: rtl/vga_timing_pkg.sv
// Shared timing constants for the VGA timing controller (1024x768 default frame).
package vga_timing_pkg;

    localparam int unsigned COUNTER_WIDTH = 11;
    localparam int unsigned COUNT_ZERO    = 0;
    localparam int unsigned H_ACTIVE      = 1024;
    localparam int unsigned V_ACTIVE      = 768;
    localparam int unsigned H_TOTAL       = 1368;
    localparam int unsigned V_TOTAL       = 806;

    // Last value a counter reaches before wrapping.
    function automatic int unsigned last_count(input int unsigned total);
        return total - 1;
    endfunction

endpackage

// File: rtl/vga_timing_controller_if.sv
// Video timing bundle from the timing controller to the downstream pixel source.
interface vga_timing_controller_if #(
    parameter int unsigned COUNTER_SIZE = 11
);
    logic                    h_sync;
    logic                    v_sync;
    logic [COUNTER_SIZE-1:0] h_count;
    logic [COUNTER_SIZE-1:0] v_count;
    logic                    display_enable;
    logic                    frame_start;

    modport master (
        output h_sync, v_sync, h_count, v_count, display_enable, frame_start
    );

    modport slave (
        input h_sync, v_sync, h_count, v_count, display_enable, frame_start
    );
endinterface

// File: rtl/vga_wrap_counter.sv
// Enabled up-counter that wraps to START after wrap_value; exposes next state and wrap pulse.
module vga_wrap_counter
    import vga_timing_pkg::*;
#(
    parameter int unsigned WIDTH = COUNTER_WIDTH,
    parameter int unsigned START = COUNT_ZERO
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] wrap_value,
    output logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] count_next,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] START_C = WIDTH'(START);

    always_comb begin
        wrap       = en && (count == wrap_value);
        count_next = count;
        if (en) begin
            count_next = wrap ? START_C : count + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= START_C;
        end else begin
            count <= count_next;
        end
    end

endmodule

// File: rtl/vga_timing_controller.sv
// Free-running VGA timing generator: pixel/line counters plus registered sync decode.
// Define VGA_SYNC_ACTIVE_LOW_EN for sync pins that are low in the active region.
module vga_timing_controller
    import vga_timing_pkg::*;
#(
    parameter int unsigned ZERO                   = COUNT_ZERO,
    parameter int unsigned THRESHOLD_HSYNC        = H_ACTIVE,
    parameter int unsigned THRESHOLD_VSYNC        = V_ACTIVE,
    parameter int unsigned WHOLE_FRAME_VERTICAL   = H_TOTAL,
    parameter int unsigned WHOLE_FRAME_HORIZONTAL = V_TOTAL,
    parameter int unsigned COUNTER_SIZE           = COUNTER_WIDTH
) (
    input  logic                     control_clock,
    input  logic                     control_reset_n,
    vga_timing_controller_if.master  video
);

    typedef logic [COUNTER_SIZE-1:0] count_t;

    localparam count_t ZERO_C = count_t'(ZERO);
    localparam count_t H_TH   = count_t'(THRESHOLD_HSYNC);
    localparam count_t V_TH   = count_t'(THRESHOLD_VSYNC);
    localparam count_t H_LAST = count_t'(last_count(WHOLE_FRAME_VERTICAL));
    localparam count_t V_LAST = count_t'(last_count(WHOLE_FRAME_HORIZONTAL));

`ifdef VGA_SYNC_ACTIVE_LOW_EN
    localparam logic SYNC_INVERT = 1'b1;
`else
    localparam logic SYNC_INVERT = 1'b0;
`endif

    count_t h_count;
    count_t h_next;
    count_t v_count;
    count_t v_next;
    logic   h_wrap;
    logic   v_wrap;
    logic   h_sync_q;
    logic   v_sync_q;
    logic   display_enable_q;
    logic   frame_start_q;
    logic   h_active;
    logic   v_active;

    vga_wrap_counter #(
        .WIDTH (COUNTER_SIZE),
        .START (ZERO)
    ) h_counter (
        .clk        (control_clock),
        .rst_n      (control_reset_n),
        .en         (1'b1),
        .wrap_value (H_LAST),
        .count      (h_count),
        .count_next (h_next),
        .wrap       (h_wrap)
    );

    vga_wrap_counter #(
        .WIDTH (COUNTER_SIZE),
        .START (ZERO)
    ) v_counter (
        .clk        (control_clock),
        .rst_n      (control_reset_n),
        .en         (h_wrap),
        .wrap_value (V_LAST),
        .count      (v_count),
        .count_next (v_next),
        .wrap       (v_wrap)
    );

    // Decoding from next-state counts keeps outputs registered yet aligned with the counters.
    always_comb begin
        h_active = (h_next < H_TH);
        v_active = (v_next < V_TH);
    end

    always_ff @(posedge control_clock or negedge control_reset_n) begin
        if (!control_reset_n) begin
            h_sync_q         <= 1'b1 ^ SYNC_INVERT;
            v_sync_q         <= 1'b1 ^ SYNC_INVERT;
            display_enable_q <= 1'b1;
            frame_start_q    <= 1'b1;
        end else begin
            h_sync_q         <= h_active ^ SYNC_INVERT;
            v_sync_q         <= v_active ^ SYNC_INVERT;
            display_enable_q <= h_active && v_active;
            frame_start_q    <= (h_next == ZERO_C) && (v_next == ZERO_C);
        end
    end

    always_comb begin
        video.h_sync         = h_sync_q;
        video.v_sync         = v_sync_q;
        video.h_count        = h_count;
        video.v_count        = v_count;
        video.display_enable = display_enable_q;
        video.frame_start    = frame_start_q;
    end

    logic unused_v_wrap;
    assign unused_v_wrap = v_wrap;

endmodule

// File: tb/tb_vga_timing_controller.sv
// Directed bench: default-size controller for line timing, shrunken instance for frame/wrap timing.
module tb_vga_timing_controller;

    localparam int unsigned SH_ACT = 10;
    localparam int unsigned SH_TOT = 16;
    localparam int unsigned SV_ACT = 5;
    localparam int unsigned SV_TOT = 8;

`ifdef VGA_SYNC_ACTIVE_LOW_EN
    localparam logic ACT = 1'b0;
`else
    localparam logic ACT = 1'b1;
`endif

    logic clk     = 1'b0;
    logic rst_n   = 1'b0;
    logic rst_s_n = 1'b0;
    int   passed  = 0;
    int   total   = 0;

    always #6 clk = ~clk;

    vga_timing_controller_if #(.COUNTER_SIZE(11)) vid ();
    vga_timing_controller_if #(.COUNTER_SIZE(11)) vid_s ();

    vga_timing_controller dut (
        .control_clock   (clk),
        .control_reset_n (rst_n),
        .video           (vid)
    );

    vga_timing_controller #(
        .THRESHOLD_HSYNC        (SH_ACT),
        .THRESHOLD_VSYNC        (SV_ACT),
        .WHOLE_FRAME_VERTICAL   (SH_TOT),
        .WHOLE_FRAME_HORIZONTAL (SV_TOT)
    ) dut_s (
        .control_clock   (clk),
        .control_reset_n (rst_s_n),
        .video           (vid_s)
    );

    task automatic test_reset();
        rst_n   = 1'b0;
        rst_s_n = 1'b0;
        repeat (5) @(negedge clk);
        total++; if (vid.h_count !== 11'd0) $display("FAIL reset_h_count: got %0d want 0", vid.h_count); else passed++;
        total++; if (vid.v_count !== 11'd0) $display("FAIL reset_v_count: got %0d want 0", vid.v_count); else passed++;
        total++; if (vid.h_sync !== ACT) $display("FAIL reset_h_sync: got %b want %b", vid.h_sync, ACT); else passed++;
        total++; if (vid.v_sync !== ACT) $display("FAIL reset_v_sync: got %b want %b", vid.v_sync, ACT); else passed++;
        total++; if (vid.display_enable !== 1'b1) $display("FAIL reset_de: got %b want 1", vid.display_enable); else passed++;
        total++; if (vid.frame_start !== 1'b1) $display("FAIL reset_fs: got %b want 1", vid.frame_start); else passed++;
        total++; if (vid_s.h_count !== 11'd0) $display("FAIL reset_small_h: got %0d want 0", vid_s.h_count); else passed++;
        total++; if (vid_s.frame_start !== 1'b1) $display("FAIL reset_small_fs: got %b want 1", vid_s.frame_start); else passed++;
        rst_n   = 1'b1;
        rst_s_n = 1'b1;
        #1;
        total++; if (vid.h_count !== 11'd0) $display("FAIL release_h_count: got %0d want 0", vid.h_count); else passed++;
        @(negedge clk);
        total++; if (vid.h_count !== 11'd1) $display("FAIL first_edge_h: got %0d want 1", vid.h_count); else passed++;
        total++; if (vid.v_count !== 11'd0) $display("FAIL first_edge_v: got %0d want 0", vid.v_count); else passed++;
        total++; if (vid.frame_start !== 1'b0) $display("FAIL first_edge_fs: got %b want 0", vid.frame_start); else passed++;
        total++; if (vid.h_sync !== ACT) $display("FAIL first_edge_hs: got %b want %b", vid.h_sync, ACT); else passed++;
        total++; if (vid.display_enable !== 1'b1) $display("FAIL first_edge_de: got %b want 1", vid.display_enable); else passed++;
        total++; if (vid_s.h_count !== 11'd1) $display("FAIL first_edge_small_h: got %0d want 1", vid_s.h_count); else passed++;
    endtask

    task automatic test_line_timing();
        int          n;
        int          de_err;
        bit          found;
        logic [10:0] vb;
        found = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if (vid.h_count === 11'd1367) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        total++; if (!found) $display("FAIL line_reach_1367: got h=%0d want 1367", vid.h_count); else passed++;
        vb = vid.v_count;
        @(negedge clk);
        total++; if (vid.h_count !== 11'd0) $display("FAIL line_wrap_h: got %0d want 0", vid.h_count); else passed++;
        total++; if (vid.v_count !== vb + 11'd1) $display("FAIL line_wrap_v: got %0d want %0d", vid.v_count, vb + 11'd1); else passed++;
        total++; if (vid.h_sync !== ACT) $display("FAIL line_wrap_hs: got %b want %b", vid.h_sync, ACT); else passed++;
        de_err = 0;
        n = 0;
        while (vid.h_sync === ACT && n < 2000) begin
            if (vid.display_enable !== 1'b1) de_err++;
            n++;
            @(negedge clk);
        end
        total++; if (n != 1024) $display("FAIL line_active_len: got %0d want 1024", n); else passed++;
        n = 0;
        while (vid.h_sync === ~ACT && n < 2000) begin
            if (vid.display_enable !== 1'b0) de_err++;
            n++;
            @(negedge clk);
        end
        total++; if (n != 344) $display("FAIL line_blank_len: got %0d want 344", n); else passed++;
        total++; if (vid.h_count !== 11'd0) $display("FAIL line_period_h: got %0d want 0", vid.h_count); else passed++;
        total++; if (de_err != 0) $display("FAIL line_display_enable: got %0d bad samples want 0", de_err); else passed++;
    endtask

    task automatic test_frame_timing();
        int   n;
        int   hi;
        int   lo;
        int   changes;
        int   bad_edge;
        int   de_err;
        bit   found;
        logic prev;
        found = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (vid_s.frame_start === 1'b1) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        total++; if (!found) $display("FAIL frame_sync: got no frame_start want pulse"); else passed++;
        hi = 0; lo = 0; changes = 0; bad_edge = 0; de_err = 0;
        prev = vid_s.v_sync;
        for (int i = 0; i < 128; i++) begin
            if (vid_s.v_sync === ACT) hi++; else lo++;
            if (vid_s.v_sync !== prev) begin
                changes++;
                if (vid_s.h_count !== 11'd0) bad_edge++;
            end
            if (vid_s.display_enable !== ((vid_s.h_sync === ACT) && (vid_s.v_sync === ACT))) de_err++;
            prev = vid_s.v_sync;
            @(negedge clk);
        end
        total++; if (hi != 80) $display("FAIL frame_vsync_active: got %0d want 80", hi); else passed++;
        total++; if (lo != 48) $display("FAIL frame_vsync_blank: got %0d want 48", lo); else passed++;
        total++; if (changes != 1) $display("FAIL frame_vsync_changes: got %0d want 1", changes); else passed++;
        total++; if (bad_edge != 0) $display("FAIL frame_vsync_edge_pos: got %0d want 0", bad_edge); else passed++;
        total++; if (de_err != 0) $display("FAIL frame_display_enable: got %0d want 0", de_err); else passed++;
        total++; if (vid_s.frame_start !== 1'b1) $display("FAIL frame_restart_fs: got %b want 1", vid_s.frame_start); else passed++;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (vid_s.frame_start !== 1'b1 && n < 300);
        total++; if (n != 128) $display("FAIL frame_period: got %0d want 128", n); else passed++;
        n = 0;
        repeat (256) begin
            @(negedge clk);
            if (vid_s.frame_start === 1'b1) n++;
        end
        total++; if (n != 2) $display("FAIL frame_pulse_count: got %0d want 2", n); else passed++;
    endtask

    task automatic test_wrap_corner();
        bit found;
        found = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (vid_s.h_count === 11'd15 && vid_s.v_count === 11'd7) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        total++; if (!found) $display("FAIL wrap_reach: got h=%0d v=%0d want 15/7", vid_s.h_count, vid_s.v_count); else passed++;
        total++; if (vid_s.v_sync !== ~ACT) $display("FAIL wrap_pre_vs: got %b want %b", vid_s.v_sync, ~ACT); else passed++;
        @(negedge clk);
        total++; if (vid_s.h_count !== 11'd0) $display("FAIL wrap_h: got %0d want 0", vid_s.h_count); else passed++;
        total++; if (vid_s.v_count !== 11'd0) $display("FAIL wrap_v: got %0d want 0", vid_s.v_count); else passed++;
        total++; if (vid_s.h_sync !== ACT) $display("FAIL wrap_hs: got %b want %b", vid_s.h_sync, ACT); else passed++;
        total++; if (vid_s.v_sync !== ACT) $display("FAIL wrap_vs: got %b want %b", vid_s.v_sync, ACT); else passed++;
        total++; if (vid_s.frame_start !== 1'b1) $display("FAIL wrap_fs: got %b want 1", vid_s.frame_start); else passed++;
        total++; if (vid_s.display_enable !== 1'b1) $display("FAIL wrap_de: got %b want 1", vid_s.display_enable); else passed++;
    endtask

    task automatic test_mid_frame_reset();
        bit found;
        found = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            if (vid.h_count === 11'd500) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        total++; if (!found) $display("FAIL mid_reach_500: got h=%0d want 500", vid.h_count); else passed++;
        #2 rst_n = 1'b0;
        #1;
        total++; if (vid.h_count !== 11'd0) $display("FAIL mid_h_count: got %0d want 0", vid.h_count); else passed++;
        total++; if (vid.v_count !== 11'd0) $display("FAIL mid_v_count: got %0d want 0", vid.v_count); else passed++;
        total++; if (vid.frame_start !== 1'b1) $display("FAIL mid_fs: got %b want 1", vid.frame_start); else passed++;
        total++; if (vid.h_sync !== ACT) $display("FAIL mid_hs: got %b want %b", vid.h_sync, ACT); else passed++;

        found = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (vid_s.h_count === 11'd7 && vid_s.v_count === 11'd6) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        total++; if (!found) $display("FAIL mid_small_reach: got h=%0d v=%0d want 7/6", vid_s.h_count, vid_s.v_count); else passed++;
        #2 rst_s_n = 1'b0;
        #1;
        total++; if (vid_s.h_count !== 11'd0) $display("FAIL mid_small_h: got %0d want 0", vid_s.h_count); else passed++;
        total++; if (vid_s.v_count !== 11'd0) $display("FAIL mid_small_v: got %0d want 0", vid_s.v_count); else passed++;
        total++; if (vid_s.v_sync !== ACT) $display("FAIL mid_small_vs: got %b want %b", vid_s.v_sync, ACT); else passed++;
        total++; if (vid_s.display_enable !== 1'b1) $display("FAIL mid_small_de: got %b want 1", vid_s.display_enable); else passed++;
        total++; if (vid_s.frame_start !== 1'b1) $display("FAIL mid_small_fs: got %b want 1", vid_s.frame_start); else passed++;

        @(negedge clk);
        rst_n   = 1'b1;
        rst_s_n = 1'b1;
        repeat (3) @(negedge clk);
        total++; if (vid.h_count !== 11'd3) $display("FAIL mid_restart_h: got %0d want 3", vid.h_count); else passed++;
        total++; if (vid_s.h_count !== 11'd3) $display("FAIL mid_restart_small_h: got %0d want 3", vid_s.h_count); else passed++;
    endtask

    initial begin
        test_reset();
        test_line_timing();
        test_frame_timing();
        test_wrap_corner();
        test_mid_frame_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/vga_timing_controller.md
Name: vga_timing_controller

Overview:
- Free-running video timing generator for the display path. Default configuration is a 1024x768 frame at about 83 MHz (12 ns clock).
- Two counters run back to back: a pixel counter inside each line, and a line counter inside each frame.
- Produces registered h_sync and v_sync, plus raw counter values and a display-enable for a downstream pixel source.
- Has no data inputs. It runs continuously once reset is released.

Parameters:
- ZERO, 0: start and wrap value of both counters.
- THRESHOLD_HSYNC, 11'd1024: pixel count at which the active part of a line ends (h_sync drops).
- THRESHOLD_VSYNC, 11'd768: line count at which the active part of a frame ends (v_sync drops).
- WHOLE_FRAME_VERTICAL, 11'd1368: total clocks per line; the pixel counter wraps after this value minus 1.
- WHOLE_FRAME_HORIZONTAL, 11'd806: total lines per frame; the line counter wraps after this value minus 1.
- COUNTER_SIZE, 11: width of both counters in bits.

Ports:
- control_clock, in, 1: single clock; all logic is on its rising edge.
- control_reset_n, in, 1: reset, asynchronous and active-low.
- h_sync, out, 1: line timing; 1 during the active pixel region.
- v_sync, out, 1: frame timing; 1 during the active line region.
- h_count, out, COUNTER_SIZE: current pixel counter.
- v_count, out, COUNTER_SIZE: current line counter.
- display_enable, out, 1: equals h_sync AND v_sync.
- frame_start, out, 1: one-cycle pulse while h_count==ZERO and v_count==ZERO.

Behaviour:
- Reset (asynchronous, control_reset_n=0):
  - h_count=ZERO and v_count=ZERO.
  - h_sync=1, v_sync=1, display_enable=1, frame_start=1.
  - Reset asserted mid-frame restarts immediately at these values.
- Pixel counter: each rising edge out of reset, h_count increments by 1. When h_count==WHOLE_FRAME_VERTICAL-1 it wraps to ZERO on the next edge.
- Line counter: v_count increments only on the edge where h_count wraps. When v_count==WHOLE_FRAME_HORIZONTAL-1 and h_count wraps, v_count wraps to ZERO.
- Counter arithmetic is unsigned at COUNTER_SIZE bits. Parameters must satisfy:
  - ZERO < THRESHOLD_HSYNC < WHOLE_FRAME_VERTICAL ≤ 2^COUNTER_SIZE.
  - The same ordering for the vertical parameters.
  - No saturation logic is required.
- All outputs are registered. Each one is computed from the next-state counter values, so in every cycle:
  - h_sync == (h_count < THRESHOLD_HSYNC)
  - v_sync == (v_count < THRESHOLD_VSYNC)
  - display_enable == h_sync & v_sync
  - frame_start == (h_count==ZERO && v_count==ZERO)
  - This means zero cycles of lag relative to the exposed counters, and no combinational glitches on outputs.
- Default timing:
  - Line: 1368 clocks, with h_sync high for 1024 and low for 344.
  - Frame: 806 lines = 1,102,608 clocks.
  - v_sync high for 768 lines (1,050,624 clocks) and low for 38 lines (51,984 clocks).
- h_sync and v_sync change only on counter transitions. A change of v_sync coincides with the cycle where h_count==ZERO.

Optional Feature:
- Macro: VGA_SYNC_ACTIVE_LOW_EN.
- When defined:
  - h_sync and v_sync are inverted: 0 in the active region, 1 in blanking.
  - Reset values become h_sync=0 and v_sync=0.
  - display_enable and frame_start are unchanged; they are decoded from the counters, not from the sync pins.
- When undefined: polarity as given under Behaviour.

Decomposition:
- Shared package vga_timing_pkg holds:
  - default timing constants (1024, 768, 1368, 806, 11);
  - a counter-width localparam.
- One natural sub-module, vga_wrap_counter. It is a parameterised counter with:
  - inputs: increment enable and wrap value;
  - outputs: count value and a wrap pulse.
- It is instantiated twice, with the horizontal wrap pulse driving the vertical enable.
- The top level adds the output decode and registers.

Test Plan:
- Reset: hold control_reset_n=0 for 5 clocks, then release → h_count=0, v_count=0, h_sync=1, v_sync=1, frame_start=1. After the first edge, h_count=1 and frame_start=0.
- Line timing: measure h_sync → high 1024 clocks, low 344 clocks, period 1368. At h_count=1367, the next edge gives h_count=0 and v_count+1.
- Frame timing: run a full frame → v_sync high 1,050,624 clocks, low 51,984 clocks. frame_start pulses once every 1,102,608 clocks.
- Wrap corner: at h_count=1367 and v_count=805, one edge → both counters are 0, and v_sync, h_sync and frame_start are all 1.
- Mid-frame reset: assert control_reset_n=0 asynchronously at h_count=500, v_count=400 → outputs return to reset values without waiting for a clock edge.
- With VGA_SYNC_ACTIVE_LOW_EN defined, repeat the line-timing test → h_sync low 1024 clocks, high 344 clocks; display_enable unchanged.
